// File: rtl/fsk_demodulate.sv
// FSK receiver: times carrier half-periods, votes high/low tone per bit window,
// strobes the recovered bit one clock after each window closes.
module fsk_demodulate #(
  parameter int HALF_HI  = 4,
  parameter int HALF_LO  = 8,
  parameter int THRESH   = 6,
  parameter int MIN_HALF = 2,
  parameter int MAX_HALF = 12,
  parameter int BIT_CLKS = 32,
  parameter int TIMEOUT  = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic wave_in,
  input  logic in_valid,
  output logic bit_out,
  output logic bit_valid,
  output logic locked,
  output logic vote_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int VW = $clog2(BIT_CLKS / MIN_HALF + 1);
  localparam int WW = $clog2(BIT_CLKS);

  if (HALF_HI > THRESH || HALF_LO <= THRESH || TIMEOUT <= MAX_HALF) begin : g_bad_cfg
    $error("fsk_demodulate: tone/threshold/timeout parameters are inconsistent");
  end

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t        r_state;
  logic          r_wave_d;
  logic [CW-1:0] r_half_cnt;
  logic [WW-1:0] r_win_cnt;
  logic [VW-1:0] r_hi_votes;
  logic [VW-1:0] r_lo_votes;
  logic          r_bit_out;
  logic          r_bit_valid;
  logic          r_locked;
  logic          r_vote_err;

  logic          w_edge;
  logic          w_vote_hi;
  logic          w_vote_lo;
  logic          w_timeout;
  logic          w_win_end;
  logic [CW-1:0] w_half_inc;
  logic [VW-1:0] w_hi_next;
  logic [VW-1:0] w_lo_next;

  assign w_edge     = wave_in ^ r_wave_d;
  assign w_half_inc = (r_half_cnt == CW'(TIMEOUT)) ? r_half_cnt : r_half_cnt + 1'b1;
  assign w_vote_hi  = w_edge && (r_half_cnt >= CW'(MIN_HALF)) && (r_half_cnt <= CW'(THRESH));
  assign w_vote_lo  = w_edge && (r_half_cnt > CW'(THRESH)) && (r_half_cnt <= CW'(MAX_HALF));
  assign w_hi_next  = (w_vote_hi && r_hi_votes != '1) ? r_hi_votes + 1'b1 : r_hi_votes;
  assign w_lo_next  = (w_vote_lo && r_lo_votes != '1) ? r_lo_votes + 1'b1 : r_lo_votes;
  assign w_timeout  = (r_half_cnt == CW'(TIMEOUT));
  assign w_win_end  = (r_win_cnt == WW'(BIT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wave_d    <= 1'b0;
      r_half_cnt  <= '0;
      r_win_cnt   <= '0;
      r_hi_votes  <= '0;
      r_lo_votes  <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_vote_err  <= 1'b0;
    end else begin
      r_wave_d    <= wave_in;
      r_bit_valid <= 1'b0;
      if (!in_valid) begin
        r_state    <= IDLE;
        r_half_cnt <= '0;
        r_win_cnt  <= '0;
        r_hi_votes <= '0;
        r_lo_votes <= '0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= ACQUIRE;
            r_half_cnt <= '0;
          end
          // The acquiring edge only sets the phase reference; it casts no vote.
          ACQUIRE: begin
            if (w_edge) begin
              r_state    <= TRACK;
              r_locked   <= 1'b1;
              r_half_cnt <= CW'(1);
              r_win_cnt  <= '0;
              r_hi_votes <= '0;
              r_lo_votes <= '0;
            end
          end
          TRACK: begin
            if (w_timeout) begin
              r_state    <= ACQUIRE;
              r_locked   <= 1'b0;
              r_half_cnt <= '0;
              r_win_cnt  <= '0;
              r_hi_votes <= '0;
              r_lo_votes <= '0;
            end else begin
              r_half_cnt <= w_edge ? CW'(1) : w_half_inc;
              if (w_win_end) begin
                r_win_cnt   <= '0;
                r_hi_votes  <= '0;
                r_lo_votes  <= '0;
                r_bit_valid <= 1'b1;
                r_bit_out   <= (w_hi_next > w_lo_next);
                r_vote_err  <= (w_hi_next == w_lo_next);
              end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_hi_votes <= w_hi_next;
                r_lo_votes <= w_lo_next;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign locked    = r_locked;
  assign vote_err  = r_vote_err;
endmodule

// File: tb/tb_fsk_demodulate.sv
// Bench for fsk_demodulate: window vector table, hand sequences for lock/tie/timeout/reset,
// and a randomized carrier checked every cycle against a time-based reference model.
module tb_fsk_demodulate;
  localparam int MIN_HALF = 2;
  localparam int THRESH   = 6;
  localparam int MAX_HALF = 12;
  localparam int BIT_CLKS = 32;
  localparam int TIMEOUT  = 24;

  logic clk = 1'b0;
  logic rst;
  logic wave_in;
  logic in_valid;
  logic bit_out;
  logic bit_valid;
  logic locked;
  logic vote_err;

  int checks = 0;
  int errors = 0;

  fsk_demodulate #(
    .HALF_HI(4), .HALF_LO(8), .THRESH(THRESH), .MIN_HALF(MIN_HALF),
    .MAX_HALF(MAX_HALF), .BIT_CLKS(BIT_CLKS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wave_in(wave_in), .in_valid(in_valid),
    .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked), .vote_err(vote_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: tracks absolute cycle numbers of the last edge and window start.
  int cyc = 0;
  bit m_prev, m_armed, m_trk;
  int m_last, m_wstart, m_hi, m_lo;
  bit e_bit, e_valid, e_lock, e_err;

  typedef struct packed {logic b; logic e;} strobe_t;
  strobe_t log_q[$];

  typedef struct {int half; int gpos; bit exp_bit; bit exp_err;} win_vec_t;
  win_vec_t vecs[12];
  int hchoice[0:16];
  bit lvl;
  int hold, vgap;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_armed = 1'b0; m_trk = 1'b0;
    m_hi = 0; m_lo = 0;
    e_bit = 1'b0; e_valid = 1'b0; e_lock = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit ed;
    int m;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      ed = (wave_in != m_prev);
      m_prev = wave_in;
      e_valid = 1'b0;
      if (!in_valid) begin
        m_armed = 1'b0; m_trk = 1'b0; e_lock = 1'b0;
      end else if (!m_armed) begin
        m_armed = 1'b1;
      end else if (!m_trk) begin
        if (ed) begin
          m_trk = 1'b1; e_lock = 1'b1; m_last = cyc; m_wstart = cyc + 1;
          m_hi = 0; m_lo = 0;
        end
      end else if (cyc - m_last >= TIMEOUT) begin
        m_trk = 1'b0; e_lock = 1'b0;
      end else begin
        if (ed) begin
          m = cyc - m_last;
          if (m >= MIN_HALF && m <= THRESH) m_hi++;
          else if (m > THRESH && m <= MAX_HALF) m_lo++;
          m_last = cyc;
        end
        if ((cyc - m_wstart) % BIT_CLKS == BIT_CLKS - 1) begin
          e_valid = 1'b1;
          e_bit = (m_hi > m_lo);
          e_err = (m_hi == m_lo);
          m_hi = 0; m_lo = 0;
        end
      end
    end
  endtask

  task automatic step(bit w, bit v);
    wave_in = w;
    in_valid = v;
    @(posedge clk);
    model_step();
    #1;
    check("cycle {lock,vld,bit,err}", {locked, bit_valid, bit_out, vote_err},
          {e_lock, e_valid, e_bit, e_err});
    if (bit_valid) log_q.push_back('{b: bit_out, e: vote_err});
  endtask

  task automatic toggle_after(int h);
    for (int i = 1; i <= h; i++) begin
      if (i == h) lvl = ~lvl;
      step(lvl, 1'b1);
    end
  endtask

  initial begin
    vecs[0]  = '{4, 0, 1'b1, 1'b0};
    vecs[1]  = '{4, 0, 1'b1, 1'b0};
    vecs[2]  = '{4, 0, 1'b1, 1'b0};
    vecs[3]  = '{4, 0, 1'b1, 1'b0};
    vecs[4]  = '{4, 0, 1'b1, 1'b0};
    vecs[5]  = '{8, 0, 1'b0, 1'b0};
    vecs[6]  = '{4, 0, 1'b1, 1'b0};
    vecs[7]  = '{4, 0, 1'b1, 1'b0};
    vecs[8]  = '{8, 0, 1'b0, 1'b0};
    vecs[9]  = '{8, 12, 1'b0, 1'b0};
    vecs[10] = '{8, 20, 1'b0, 1'b0};
    vecs[11] = '{16, 0, 1'b0, 1'b1};
    hchoice = '{1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 8, 8, 10, 12, 13, 20, 26};

    rst = 1'b1; wave_in = 1'b0; in_valid = 1'b0; lvl = 1'b0;
    model_reset();
    step(1'b0, 1'b0);
    check("reset outputs", {locked, bit_valid, bit_out, vote_err}, 4'b0000);
    step(1'b0, 1'b0);
    rst = 1'b0;

    // Acquire on the first edge after arming.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("unlocked before first edge", locked, 1'b0);
    lvl = 1'b1;
    step(lvl, 1'b1);
    check("locked one clk after first edge", locked, 1'b1);

    // Window-aligned tone table: strobe must land on the last clock of each window.
    for (int k = 0; k < 12; k++) begin
      for (int j = 1; j <= BIT_CLKS; j++) begin
        if (j % vecs[k].half == 0) lvl = ~lvl;
        step(lvl ^ (j == vecs[k].gpos), 1'b1);
      end
      check($sformatf("win%0d bit_valid", k), bit_valid, 1'b1);
      check($sformatf("win%0d bit_out", k), bit_out, vecs[k].exp_bit);
      check($sformatf("win%0d vote_err", k), vote_err, vecs[k].exp_err);
    end

    // Tie window: 3 votes at m=8 then 3 at m=4, the last on win_cnt=31.
    log_q.delete();
    for (int i = 0; i < 7; i++) toggle_after(4);
    toggle_after(8); toggle_after(8); toggle_after(8);
    toggle_after(4); toggle_after(4); toggle_after(4);
    for (int i = 0; i < 8; i++) toggle_after(4);
    check("tie seq strobe count", log_q.size(), 3);
    check("tie seq w1", log_q[0], 2'b10);
    check("tie seq w2 tie", log_q[1], 2'b01);
    check("tie seq w3", log_q[2], 2'b10);

    // Carrier loss: timeout coincides with window close and must suppress the strobe.
    log_q.delete();
    toggle_after(4); toggle_after(4);
    for (int i = 0; i < 23; i++) step(lvl, 1'b1);
    check("lock held before timeout", locked, 1'b1);
    step(lvl, 1'b1);
    check("timeout drops lock", locked, 1'b0);
    check("timeout beats window close", bit_valid, 1'b0);
    for (int i = 0; i < 5; i++) step(lvl, 1'b1);
    check("no strobe for lost window", log_q.size(), 0);
    lvl = ~lvl;
    step(lvl, 1'b1);
    check("relock on next edge", locked, 1'b1);
    for (int i = 0; i < 16; i++) toggle_after(4);
    check("post-relock strobes", log_q.size(), 2);
    check("post-relock bit", log_q[1], 2'b10);

    // in_valid drop mid-window.
    log_q.delete();
    for (int i = 0; i < 3; i++) toggle_after(4);
    step(lvl, 1'b0);
    check("in_valid drop unlocks", locked, 1'b0);
    for (int i = 0; i < 5; i++) toggle_after(4);
    check("no strobe after in_valid drop", log_q.size(), 0);
    for (int i = 0; i < 8; i++) toggle_after(4);
    check("decode after re-acquire", log_q.size(), 1);
    check("decode after re-acquire bit", log_q[0], 2'b10);

    // Async reset while a strobe is on the outputs.
    for (int i = 0; i < 4; i++) toggle_after(4);
    check("strobe before reset", {bit_valid, bit_out}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", {locked, bit_valid, bit_out, vote_err}, 4'b0000);
    model_reset();
    step(lvl, 1'b1);
    rst = 1'b0;
    log_q.delete();
    step(lvl, 1'b1);
    check("idle after reset release", locked, 1'b0);
    for (int i = 0; i < 10; i++) toggle_after(4);
    check("restart after fresh acquire", log_q.size(), 1);
    check("restart lock", locked, 1'b1);

    // Randomized carrier with glitches, long gaps and in_valid drops.
    hold = 1; vgap = 0;
    for (int i = 0; i < 4000; i++) begin
      if (vgap == 0 && $urandom_range(0, 399) == 0) vgap = $urandom_range(1, 3);
      hold--;
      if (hold <= 0) begin
        lvl = ~lvl;
        hold = hchoice[$urandom_range(0, 16)];
      end
      step(lvl, vgap == 0);
      if (vgap > 0) vgap--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsk_demodulate.md
Name: fsk_demodulate

Overview:
- Receive-side counterpart of the FSK modulator; consumes its single-bit square-wave carrier and recovers the transmitted bit stream.
- Timing method: measures the clock count between carrier edges, classifies each half-period as high tone or low tone, and majority-votes the half-periods over each bit window.
- Placement: directly downstream of the modulator in the loopback/channel path, same clock domain, no CDC.

Parameters:
- HALF_HI, 4: nominal half-period (clocks) of the tone carrying bit 1.
- HALF_LO, 8: nominal half-period (clocks) of the tone carrying bit 0.
- THRESH, 6: a measured half-period <= THRESH counts as a high-tone vote; above it counts as a low-tone vote.
- MIN_HALF, 2: half-periods shorter than this are glitches and are ignored.
- MAX_HALF, 12: half-periods longer than this are ignored.
- BIT_CLKS, 32: clocks per bit window.
- TIMEOUT, 24: clocks without an edge before lock is declared lost; must exceed MAX_HALF.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- wave_in, in, 1: FSK carrier from the modulator.
- in_valid, in, 1: carrier-present qualifier (same signal that enables the modulator).
- bit_out, out, 1: recovered bit; held until the next bit_valid.
- bit_valid, out, 1: one-cycle strobe; bit_out is new this cycle.
- locked, out, 1: high while in TRACK.
- vote_err, out, 1: qualifies each bit_valid; high when the window's vote was a tie or had no votes.

Behaviour:
- Reset (async, rst=1): all registers 0, state IDLE. Outputs bit_out=0, bit_valid=0, locked=0, vote_err=0.
- Edge detect: wave_d <= wave_in every cycle; edge = wave_in ^ wave_d. No input synchroniser.
- Half-period counter half_cnt:
  - Width $clog2(TIMEOUT+1); saturates at TIMEOUT.
  - On edge: measured length m = half_cnt, then half_cnt <= 1.
  - Otherwise half_cnt increments.
  - A carrier toggling every 4 clocks therefore yields m=4.
- Vote classification (TRACK only, on edge):
  - MIN_HALF <= m <= THRESH -> hi_votes+1.
  - THRESH < m <= MAX_HALF -> lo_votes+1.
  - Any other m -> no vote.
  - Vote counters saturate; width $clog2(BIT_CLKS/MIN_HALF+1).
- State machine:
  - IDLE: wait for in_valid=1 -> ACQUIRE.
  - ACQUIRE: first edge -> TRACK with half_cnt=1, win_cnt=0, votes=0. That edge casts no vote.
  - TRACK: win_cnt counts 0..BIT_CLKS-1. On the cycle win_cnt==BIT_CLKS-1 the window closes:
    - hi>lo -> bit_out=1, vote_err=0.
    - lo>hi -> bit_out=0, vote_err=0.
    - tie or both zero -> bit_out=0, vote_err=1.
    - bit_valid=1 on the next cycle only (registered outputs).
    - win_cnt wraps to 0 and votes clear.
  - vote_err is updated only at window close and holds otherwise.
- Latency: bit_valid is asserted 1 clock after the last clock of its window. Back-to-back windows produce strobes exactly BIT_CLKS clocks apart.
- Simultaneous events:
  - An edge on the window-closing cycle votes into the closing window; the next window starts with zero votes.
  - Timeout and window close in the same cycle: timeout wins; no strobe.
- Timeout: half_cnt reaching TIMEOUT in TRACK -> ACQUIRE, locked=0. The partial window is discarded (no bit_valid). bit_out holds its last value.
- in_valid=0 in any state -> IDLE next cycle; counters and votes clear; locked=0; bit_valid=0; bit_out holds.
- locked = (state==TRACK), registered.
- Reset mid-operation: immediate return to reset values, including a bit_valid in flight.

Test Plan:
- Steady high tone: in_valid=1, wave toggling every 4 clk for 5 windows -> locked=1 one clk after first edge; 5 bit_valid strobes 32 clk apart, each bit_out=1, vote_err=0.
- Alternating pattern: 4 windows of low, high, high, low tone (8/4/4/8 half-periods) aligned to window starts -> bits 0,1,1,0.
- Glitch rejection: inject 1-clk pulses into a low tone -> glitch halves (m<2) ignored; each window still decodes 0, vote_err=0.
- Carrier loss: stop toggling mid-window for 24 clk -> locked falls, no bit_valid for the partial window; resume toggling -> relock on the next edge.
- Tie and edge cases:
  - Window with 3 votes at m=4 and 3 at m=8 -> bit_out=0, vote_err=1.
  - Edge on win_cnt=31 counts toward the closing window.
- Control: drop in_valid mid-window -> IDLE, no strobe. Assert rst mid-window -> all outputs 0 asynchronously; decoding restarts only after a fresh ACQUIRE.
